// File: rtl/lift_step_par.sv
// rtl/lift_step_par.sv - N-lane 5/3 integer lifting step with a 2-stage valid/ready pipeline
//
// Purpose: applies one 5/3 lifting step (predict or update, forward or inverse) to every
// lane of a packed vector per beat.
// Stage 1 registers the neighbour sum, the sample, the per-lane ops and the inv flag.
// Stage 2 registers the narrowed result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input beat handshake (in_ready = not stalled)
//   inv                   0 forward, 1 inverse; taken with the beat
//   left_i, sam_i,        LANES x W signed lanes, lane k at [k*W +: W]
//   right_i
//   op_i                  LANES x 2: 00 pass, 01 predict, 10 update, 11 pass
//   out_valid / out_ready result beat handshake
//   res_o                 lifted samples, held while stalled
//   noupdate_o            every lane of the current result was a pass
//   ovf_o                 sticky narrowing event flag
//   clr_i                 synchronous clear of ovf_o and beat_cnt_o
//   beat_cnt_o            result beats accepted downstream, wrapping
module lift_step_par #(
  parameter int LANES = 16,
  parameter int W     = 9,
  parameter int SAT   = 1,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inv,
  input  logic [LANES*W-1:0]   left_i,
  input  logic [LANES*W-1:0]   sam_i,
  input  logic [LANES*W-1:0]   right_i,
  input  logic [LANES*2-1:0]   op_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   res_o,
  output logic                 noupdate_o,
  output logic                 ovf_o,
  input  logic                 clr_i,
  output logic [CNTW-1:0]      beat_cnt_o
);

  localparam int SW   = W + 1;
  localparam int XW   = W + 2;
  localparam int MAXI = (1 << (W - 1)) - 1;
  localparam int MINI = -(1 << (W - 1));
  localparam logic signed [XW-1:0] MAXV = XW'(MAXI);
  localparam logic signed [XW-1:0] MINV = XW'(MINI);
  localparam logic signed [XW-1:0] TWO  = XW'(2);

  logic                 s1_v_q, s1_v_d;
  logic [LANES*SW-1:0]  s1_sum_q, s1_sum_d;
  logic [LANES*W-1:0]   s1_sam_q, s1_sam_d;
  logic [LANES*2-1:0]   s1_op_q, s1_op_d;
  logic                 s1_inv_q, s1_inv_d;
  logic                 out_valid_q, out_valid_d;
  logic [LANES*W-1:0]   res_q, res_d;
  logic                 nu_q, nu_d;
  logic                 ovf_q, ovf_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  logic                 stall;
  logic signed [XW-1:0] sx, xs, d, y;
  logic [1:0]           op;
  logic                 sub;
  logic [W-1:0]         r;
  logic [LANES*W-1:0]   res_calc;
  logic                 lane_ovf;
  logic                 all_pass;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Stage 1: capture the beat and form l+r at W+1 bits so the sum never overflows.
  always_comb begin
    s1_v_d   = s1_v_q;
    s1_sum_d = s1_sum_q;
    s1_sam_d = s1_sam_q;
    s1_op_d  = s1_op_q;
    s1_inv_d = s1_inv_q;
    if (!stall) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sam_d = sam_i;
        s1_op_d  = op_i;
        s1_inv_d = inv;
        for (int k = 0; k < LANES; k++) begin
          s1_sum_d[k*SW +: SW] = {left_i[k*W + W-1], left_i[k*W +: W]}
                               + {right_i[k*W + W-1], right_i[k*W +: W]};
        end
      end
    end
  end

  // Per-lane lifting arithmetic on the stage-1 registers; W+2 bits holds every y exactly.
  always_comb begin
    sx       = '0;
    xs       = '0;
    d        = '0;
    y        = '0;
    op       = '0;
    sub      = 1'b0;
    r        = '0;
    res_calc = '0;
    lane_ovf = 1'b0;
    all_pass = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      sx = {s1_sum_q[k*SW + SW-1], s1_sum_q[k*SW +: SW]};
      xs = {{2{s1_sam_q[k*W + W-1]}}, s1_sam_q[k*W +: W]};
      op = s1_op_q[2*k +: 2];
      case (op)
        2'b01: begin
          d   = sx >>> 1;
          sub = ~s1_inv_q;
        end
        2'b10: begin
          d   = (sx + TWO) >>> 2;
          sub = s1_inv_q;
        end
        default: begin
          d   = '0;
          sub = 1'b0;
        end
      endcase
      y = sub ? (xs - d) : (xs + d);
      if (y > MAXV) begin
        lane_ovf = 1'b1;
        r = (SAT != 0) ? MAXV[W-1:0] : y[W-1:0];
      end else if (y < MINV) begin
        lane_ovf = 1'b1;
        r = (SAT != 0) ? MINV[W-1:0] : y[W-1:0];
      end else begin
        r = y[W-1:0];
      end
      res_calc[k*W +: W] = r;
      // 00 and 11 are both pass: the two op bits are equal.
      if (op[1] != op[0]) all_pass = 1'b0;
    end
  end

  // Stage 2 plus the sticky flag and beat counter; a same-cycle ovf event overrides clr_i.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    nu_d        = nu_q;
    if (!stall) begin
      out_valid_d = s1_v_q;
      if (s1_v_q) begin
        res_d = res_calc;
        nu_d  = all_pass;
      end
    end
    ovf_d = ovf_q;
    if (clr_i) ovf_d = 1'b0;
    if (!stall && s1_v_q && lane_ovf) ovf_d = 1'b1;
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (out_valid_q && out_ready) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_sum_q    <= '0;
      s1_sam_q    <= '0;
      s1_op_q     <= '0;
      s1_inv_q    <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      nu_q        <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_sum_q    <= s1_sum_d;
      s1_sam_q    <= s1_sam_d;
      s1_op_q     <= s1_op_d;
      s1_inv_q    <= s1_inv_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      nu_q        <= nu_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign res_o      = res_q;
  assign noupdate_o = nu_q;
  assign ovf_o      = ovf_q;
  assign beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_lift_step_par.sv
// tb/tb_lift_step_par.sv - self-checking bench for lift_step_par (saturating and wrapping builds)
module tb_lift_step_par;

  localparam int LANES = 16;
  localparam int W     = 9;
  localparam int CNTW  = 16;
  localparam int MAXI  = (1 << (W - 1)) - 1;
  localparam int MINI  = -(1 << (W - 1));
  localparam int WCNT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, inv, out_valid, out_ready, noupdate_o, ovf_o, clr_i;
  logic [LANES*W-1:0]   left_i, sam_i, right_i, res_o;
  logic [LANES*2-1:0]   op_i;
  logic [CNTW-1:0]      beat_cnt_o;
  logic                 w_in_ready, w_out_valid, w_nu, w_ovf;
  logic [W-1:0]         w_res;
  logic [WCNT-1:0]      w_cnt;

  lift_step_par #(.LANES(LANES), .W(W), .SAT(1), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
    .left_i(left_i), .sam_i(sam_i), .right_i(right_i), .op_i(op_i),
    .out_valid(out_valid), .out_ready(out_ready), .res_o(res_o), .noupdate_o(noupdate_o),
    .ovf_o(ovf_o), .clr_i(clr_i), .beat_cnt_o(beat_cnt_o));

  // Single-lane wrapping build with a tiny counter, fed from lane 0 of the same stream.
  lift_step_par #(.LANES(1), .W(W), .SAT(0), .CNTW(WCNT)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .inv(inv),
    .left_i(left_i[W-1:0]), .sam_i(sam_i[W-1:0]), .right_i(right_i[W-1:0]), .op_i(op_i[1:0]),
    .out_valid(w_out_valid), .out_ready(out_ready), .res_o(w_res), .noupdate_o(w_nu),
    .ovf_o(w_ovf), .clr_i(clr_i), .beat_cnt_o(w_cnt));

  typedef struct {
    logic [LANES*W-1:0] res;
    logic               nu;
    logic               ovf;
    logic [W-1:0]       wres;
    logic               wnu;
    logic               wovf;
    int                 acc_cyc;
  } exp_t;

  typedef struct {
    int l, r, s;
    logic [1:0] op;
    logic inv;
    int y_sat, y_wrap;
    logic ovf, nu;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          cl[LANES], cr[LANES], cs[LANES];
  logic [1:0]  cop[LANES];
  logic        cinv;
  exp_t        exp_q[$];
  int          cyc_no = 0;
  int          model_cnt = 0;
  int          last_lat;
  logic [W-1:0] last_res0, last_wres;
  logic        last_nu;
  logic        acc_ovf, acc_wovf;
  vec_t        tbl[12];

  task automatic check(input string nm, input logic [LANES*W-1:0] act, input logic [LANES*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc_no);
    end
  endtask

  function automatic int fdiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int lift(int l, int r, int s, logic [1:0] op, logic iv);
    int sum;
    sum = l + r;
    if (op == 2'b01) return iv ? s + fdiv(sum, 2) : s - fdiv(sum, 2);
    if (op == 2'b10) return iv ? s - fdiv(sum + 2, 4) : s + fdiv(sum + 2, 4);
    return s;
  endfunction

  function automatic int sat(int y);
    if (y > MAXI) return MAXI;
    if (y < MINI) return MINI;
    return y;
  endfunction

  function automatic int wrapv(int y);
    return (((y - MINI) % (1 << W)) + (1 << W)) % (1 << W) + MINI;
  endfunction

  function automatic logic [W-1:0] lo(int v);
    return v[W-1:0];
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    int   y;
    logic o, p;
    e.res = '0; e.nu = 1'b1; e.ovf = 1'b0; e.wres = '0; e.wnu = 1'b0; e.wovf = 1'b0; e.acc_cyc = 0;
    for (int k = 0; k < LANES; k++) begin
      y = lift(cl[k], cr[k], cs[k], cop[k], cinv);
      o = (y > MAXI) || (y < MINI);
      p = (cop[k] == 2'b00) || (cop[k] == 2'b11);
      e.res[k*W +: W] = lo(sat(y));
      if (o) e.ovf = 1'b1;
      if (!p) e.nu = 1'b0;
      if (k == 0) begin
        e.wres = lo(wrapv(y));
        e.wnu  = p;
        e.wovf = o;
      end
    end
    return e;
  endfunction

  function automatic int rnd_s();
    return int'($urandom_range(511)) - 256;
  endfunction

  task automatic rand_lanes(input int first, input bit pass_only);
    for (int k = first; k < LANES; k++) begin
      cl[k] = rnd_s(); cr[k] = rnd_s(); cs[k] = rnd_s();
      cop[k] = pass_only ? ((k % 2) ? 2'b00 : 2'b11) : 2'($urandom_range(3));
    end
    if (first == 0) cinv = 1'($urandom_range(1));
  endtask

  // One clock: drive at the falling edge, check just after it, book acceptance for the next rise.
  task automatic cyc(input logic v, input logic ordy, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid = v; out_ready = ordy; clr_i = clr; inv = cinv;
    for (int k = 0; k < LANES; k++) begin
      left_i[k*W +: W]  = lo(cl[k]);
      right_i[k*W +: W] = lo(cr[k]);
      sam_i[k*W +: W]   = lo(cs[k]);
      op_i[2*k +: 2]    = cop[k];
    end
    #1;
    check("beat_cnt", beat_cnt_o, model_cnt % (1 << CNTW));
    check("w_beat_cnt", w_cnt, model_cnt % (1 << WCNT));
    check("in_ready", in_ready, !(out_valid && !out_ready));
    check("w_in_ready", w_in_ready, !(out_valid && !out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else begin
        check("res", res_o, exp_q[0].res);
        check("noupdate", noupdate_o, exp_q[0].nu);
        check("w_valid", w_out_valid, 1'b1);
        check("w_res", w_res, exp_q[0].wres);
        check("w_noupdate", w_nu, exp_q[0].wnu);
        if (out_ready) begin
          e = exp_q.pop_front();
          last_lat  = cyc_no - e.acc_cyc;
          last_res0 = res_o[W-1:0];
          last_wres = w_res;
          last_nu   = noupdate_o;
          if (!clr) model_cnt++;
        end
      end
    end
    if (clr) model_cnt = 0;
    if (in_valid && in_ready) begin
      e = make_exp();
      e.acc_cyc = cyc_no;
      acc_ovf  = acc_ovf | e.ovf;
      acc_wovf = acc_wovf | e.wovf;
      exp_q.push_back(e);
    end
    cyc_no++;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      cyc(1'b0, 1'b1, 1'b0);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, n0;
    in_valid = 0; out_ready = 1; clr_i = 0; inv = 0; cinv = 0;
    left_i = '0; right_i = '0; sam_i = '0; op_i = '0;
    acc_ovf = 0; acc_wovf = 0; last_lat = -1; last_res0 = '0; last_wres = '0; last_nu = 0;
    for (int k = 0; k < LANES; k++) begin
      cl[k] = 0; cr[k] = 0; cs[k] = 0; cop[k] = 2'b00;
    end

    tbl[0]  = '{10, 20, 100, 2'b01, 1'b0, 85, 85, 1'b0, 1'b0};
    tbl[1]  = '{10, 20, 100, 2'b10, 1'b0, 108, 108, 1'b0, 1'b0};
    tbl[2]  = '{10, 20, 100, 2'b10, 1'b1, 92, 92, 1'b0, 1'b0};
    tbl[3]  = '{10, 20, 100, 2'b01, 1'b1, 115, 115, 1'b0, 1'b0};
    tbl[4]  = '{-3, -4, 0, 2'b01, 1'b0, 4, 4, 1'b0, 1'b0};
    tbl[5]  = '{5, 7, -42, 2'b00, 1'b0, -42, -42, 1'b0, 1'b1};
    tbl[6]  = '{5, 7, 77, 2'b11, 1'b1, 77, 77, 1'b0, 1'b1};
    tbl[7]  = '{255, 255, 255, 2'b10, 1'b0, 255, -129, 1'b1, 1'b0};
    tbl[8]  = '{-256, -256, -256, 2'b10, 1'b0, -256, 128, 1'b1, 1'b0};
    tbl[9]  = '{255, 255, 255, 2'b01, 1'b1, 255, -2, 1'b1, 1'b0};
    tbl[10] = '{-256, -256, -256, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[11] = '{-1, -2, 0, 2'b10, 1'b1, 1, 1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res", res_o, '0);
    check("rst_noupdate", noupdate_o, 1'b0);
    check("rst_ovf", ovf_o, 1'b0);
    check("rst_cnt", beat_cnt_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1'b1);

    // Directed vectors on lane 0, remaining lanes pass with random data
    foreach (tbl[i]) begin
      rand_lanes(1, 1'b1);
      cl[0] = tbl[i].l; cr[0] = tbl[i].r; cs[0] = tbl[i].s; cop[0] = tbl[i].op; cinv = tbl[i].inv;
      last_lat = -1;
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check($sformatf("vec%0d_latency", i), last_lat, 2);
      check($sformatf("vec%0d_res", i), last_res0, lo(tbl[i].y_sat));
      check($sformatf("vec%0d_wrap_res", i), last_wres, lo(tbl[i].y_wrap));
      check($sformatf("vec%0d_ovf", i), ovf_o, tbl[i].ovf);
      check($sformatf("vec%0d_wrap_ovf", i), w_ovf, tbl[i].ovf);
      check($sformatf("vec%0d_noupdate", i), last_nu, tbl[i].nu);
    end
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("ovf_cleared", ovf_o, 1'b0);

    // Clear coinciding with an accepted output: counter ends at zero
    rand_lanes(0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("clr_vs_accept_cnt", beat_cnt_o, '0);

    // Clear coinciding with an overflow event: flag stays set
    rand_lanes(1, 1'b1);
    cl[0] = 255; cr[0] = 255; cs[0] = 255; cop[0] = 2'b10; cinv = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("clr_vs_ovf", ovf_o, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("ovf_clr_after", ovf_o, 1'b0);

    // Backpressure: 8 beats, out_ready 1,0,0,1,0,0...
    cyc(1'b0, 1'b1, 1'b1);
    n0 = 0; g = 0;
    while (n0 < 8 && g < 100) begin
      rand_lanes(0, 1'b0);
      if (in_ready || !(out_valid && (g % 3) != 0)) begin end
      cyc(1'b1, (g % 3) == 0, 1'b0);
      if (in_valid && in_ready) n0++;
      g++;
    end
    check("bp_accepted", n0, 8);
    while (exp_q.size() > 0 && g < 200) begin
      cyc(1'b0, (g % 3) == 0, 1'b0);
      g++;
    end
    check("bp_drained", exp_q.size(), 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("bp_beat_cnt", beat_cnt_o, 8);
    check("bp_w_cnt_wrapped", w_cnt, 0);

    // Randomised stream against the scoreboard
    cyc(1'b0, 1'b1, 1'b1);
    acc_ovf = 0; acc_wovf = 0;
    for (int i = 0; i < 400; i++) begin
      rand_lanes(0, ($urandom_range(7) == 0));
      cyc(1'($urandom_range(1)), ($urandom_range(3) != 0), 1'b0);
    end
    drain();
    cyc(1'b0, 1'b1, 1'b0);
    check("rand_ovf", ovf_o, acc_ovf);
    check("rand_w_ovf", w_ovf, acc_wovf);

    // Reset with two beats in flight
    rand_lanes(0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_w_out_valid", w_out_valid, 1'b0);
    check("reset_res", res_o, '0);
    check("reset_ovf", ovf_o, 1'b0);
    check("reset_cnt", beat_cnt_o, '0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    check("post_reset_cnt", beat_cnt_o, '0);
    check("post_reset_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
